// File: rtl/mdl_mskreg_pkg.sv
// Shared defaults and mode encoding for the bubble bootloop mask register.
package mdl_mskreg_pkg;

  localparam int unsigned MSK_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 5;

  // Value seen on i_4BEN_n
  typedef enum logic {
    MODE_4BIT = 1'b0,
    MODE_1BIT = 1'b1
  } mode_e;

  // Byte-index width of the staging buffer (never narrower than one bit)
  function automatic int unsigned ptr_width(input int unsigned msk_w);
    return (msk_w / 8 > 1) ? $clog2(msk_w / 8) : 1;
  endfunction

endpackage

// File: rtl/mdl_mskreg_stg.sv
// Byte-wise staging buffer for the next mask word: pointer, full flag and
// sticky overrun. A consume pulse frees the buffer in the same cycle.
module mdl_mskreg_stg
  import mdl_mskreg_pkg::*;
#(
  parameter int unsigned MSK_W = MSK_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [7:0]       din_i,
  input  logic             clr_i,
  input  logic             consume_i,
  output logic [MSK_W-1:0] word_o,
  output logic             full_o,
  output logic             ptr_o,
  output logic             overrun_o
);

  localparam int unsigned      PTR_W = ptr_width(MSK_W);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(MSK_W / 8 - 1);

  logic [MSK_W-1:0] stg_q, stg_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] wptr;
  logic             full_q, full_d;
  logic             ovr_q, ovr_d;
  logic             avail;

  always_comb begin
    stg_d  = stg_q;
    ptr_d  = ptr_q;
    full_d = full_q;
    ovr_d  = ovr_q;
    // A word consumed this cycle frees the buffer for a concurrent write at byte 0
    avail  = consume_i | ~full_q;
    wptr   = consume_i ? '0 : ptr_q;
    if (en_i) begin
      if (clr_i) begin
        ptr_d  = '0;
        full_d = 1'b0;
      end else begin
        if (consume_i) begin
          ptr_d  = '0;
          full_d = 1'b0;
        end
        if (wr_i) begin
          if (!avail) begin
            ovr_d = 1'b1;
          end else begin
            stg_d[{wptr, 3'b000} +: 8] = din_i;
            if (wptr == LAST) begin
              ptr_d  = '0;
              full_d = 1'b1;
            end else begin
              ptr_d = wptr + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_q  <= '0;
      ptr_q  <= '0;
      full_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      stg_q  <= stg_d;
      ptr_q  <= ptr_d;
      full_q <= full_d;
      ovr_q  <= ovr_d;
    end
  end

  assign word_o    = stg_q;
  assign full_o    = full_q;
  assign ptr_o     = ptr_q[0];
  assign overrun_o = ovr_q;

endmodule

// File: rtl/mdl_mskreg.sv
// Bubble bootloop mask shift register: loads the staged word (or reuses the
// last one) and presents one bit or one nibble per shift strobe.
module mdl_mskreg
  import mdl_mskreg_pkg::*;
#(
  parameter int unsigned MSK_W = MSK_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_MCLK,
  input  logic             i_RST,
  input  logic             i_CLK2M_PCEN_n,
  input  logic             i_4BEN_n,
  input  logic             i_MSKREG_SR_LD,
  input  logic             i_MSK_SHIFT,
  input  logic             i_STG_WR,
  input  logic [7:0]       i_STG_DIN,
  input  logic             i_STG_CLR,
  output logic             o_MSK_BIT,
  output logic [3:0]       o_MSK_NIB,
  output logic             o_STG_FULL,
  output logic             o_STG_PTR,
  output logic [CNT_W-1:0] o_BITS_LEFT,
  output logic             o_UNDERRUN,
  output logic             o_OVERRUN
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MSK_W);
  localparam logic [CNT_W-1:0] NIB_CNT  = CNT_W'(4);

  logic             en;
  mode_e            mode;
  logic [MSK_W-1:0] stg_word;
  logic             stg_full;
  logic             consume;

  logic [MSK_W-1:0] sr_q, sr_d;
  logic [MSK_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic             unf_q, unf_d;

  assign en      = ~i_CLK2M_PCEN_n;
  assign mode    = mode_e'(i_4BEN_n);
  assign consume = en & i_MSKREG_SR_LD & stg_full;

  mdl_mskreg_stg #(
    .MSK_W(MSK_W)
  ) u_stg (
    .clk_i     (i_MCLK),
    .rst_i     (i_RST),
    .en_i      (en),
    .wr_i      (i_STG_WR),
    .din_i     (i_STG_DIN),
    .clr_i     (i_STG_CLR),
    .consume_i (consume),
    .word_o    (stg_word),
    .full_o    (stg_full),
    .ptr_o     (o_STG_PTR),
    .overrun_o (o_OVERRUN)
  );

  always_comb begin
    sr_d   = sr_q;
    hold_d = hold_q;
    bits_d = bits_q;
    unf_d  = unf_q;
    if (en) begin
      if (i_MSKREG_SR_LD) begin
        // Load beats a same-cycle shift; an empty stage replays the held mask
        if (stg_full) begin
          sr_d   = stg_word;
          hold_d = stg_word;
        end else begin
          sr_d = hold_q;
        end
        bits_d = FULL_CNT;
      end else if (i_MSK_SHIFT) begin
        if (mode == MODE_1BIT) begin
          sr_d = {sr_q[MSK_W-2:0], 1'b0};
        end else begin
          sr_d = {sr_q[MSK_W-5:0], 4'b0000};
        end
        if (bits_q == '0) begin
          unf_d = 1'b1;
        end else if (mode == MODE_1BIT) begin
          bits_d = bits_q - 1'b1;
        end else if (bits_q < NIB_CNT) begin
          bits_d = '0;
        end else begin
          bits_d = bits_q - NIB_CNT;
        end
      end
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      sr_q   <= '0;
      hold_q <= '0;
      bits_q <= '0;
      unf_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      hold_q <= hold_d;
      bits_q <= bits_d;
      unf_q  <= unf_d;
    end
  end

  assign o_MSK_BIT   = sr_q[MSK_W-1];
  assign o_MSK_NIB   = sr_q[MSK_W-1 -: 4];
  assign o_STG_FULL  = stg_full;
  assign o_BITS_LEFT = bits_q;
  assign o_UNDERRUN  = unf_q;

endmodule

// File: tb/tb_mdl_mskreg.sv
// Self-checking bench for mdl_mskreg: directed table, multi-cycle corner
// sequences, then random traffic against a word-level reference model.
module tb_mdl_mskreg;

  logic       clk = 1'b0;
  logic       rst, pcen_n, ben_n, ld, sh, wr, clr;
  logic [7:0] din;
  logic       msk_bit, stg_full, stg_ptr, underrun, overrun;
  logic [3:0] msk_nib;
  logic [4:0] bits_left;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdl_mskreg #(
    .MSK_W(16),
    .CNT_W(5)
  ) dut (
    .i_MCLK         (clk),
    .i_RST          (rst),
    .i_CLK2M_PCEN_n (pcen_n),
    .i_4BEN_n       (ben_n),
    .i_MSKREG_SR_LD (ld),
    .i_MSK_SHIFT    (sh),
    .i_STG_WR       (wr),
    .i_STG_DIN      (din),
    .i_STG_CLR      (clr),
    .o_MSK_BIT      (msk_bit),
    .o_MSK_NIB      (msk_nib),
    .o_STG_FULL     (stg_full),
    .o_STG_PTR      (stg_ptr),
    .o_BITS_LEFT    (bits_left),
    .o_UNDERRUN     (underrun),
    .o_OVERRUN      (overrun)
  );

  // Reference model: mask as a plain integer, staging as an array of bytes
  int         m_sr, m_hold, m_bits, m_ptr;
  bit         m_full, m_unf, m_ovr;
  logic [7:0] m_stg[2];

  task automatic model_step(input bit r, p, b, l, s, w, c, input logic [7:0] d);
    int  n;
    bit  consumed;
    if (r) begin
      m_sr = 0; m_hold = 0; m_bits = 0; m_ptr = 0;
      m_full = 0; m_unf = 0; m_ovr = 0;
      m_stg[0] = 8'h00; m_stg[1] = 8'h00;
    end else if (!p) begin
      consumed = l && m_full;
      if (l) begin
        if (m_full) begin
          m_sr   = int'(m_stg[1]) * 256 + int'(m_stg[0]);
          m_hold = m_sr;
        end else begin
          m_sr = m_hold;
        end
        m_bits = 16;
      end else if (s) begin
        n    = b ? 1 : 4;
        m_sr = (m_sr << n) & 32'hFFFF;
        if (m_bits == 0) m_unf = 1;
        else m_bits = (m_bits > n) ? m_bits - n : 0;
      end
      if (c) begin
        m_ptr = 0; m_full = 0;
      end else begin
        if (consumed) begin
          m_ptr = 0; m_full = 0;
        end
        if (w) begin
          if (m_full) m_ovr = 1;
          else begin
            m_stg[m_ptr] = d;
            if (m_ptr == 1) begin m_full = 1; m_ptr = 0; end
            else m_ptr = 1;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, p, b, l, s, w, c, input logic [7:0] d);
    rst = r; pcen_n = p; ben_n = b; ld = l; sh = s; wr = w; clr = c; din = d;
    model_step(r, p, b, l, s, w, c, d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string pfx, input logic e_bit, input logic [3:0] e_nib,
                         input logic e_full, input logic e_ptr, input int e_bits,
                         input logic e_unf, input logic e_ovr);
    chk({pfx, ".bit"},  32'(msk_bit),   32'(e_bit));
    chk({pfx, ".nib"},  32'(msk_nib),   32'(e_nib));
    chk({pfx, ".full"}, 32'(stg_full),  32'(e_full));
    chk({pfx, ".ptr"},  32'(stg_ptr),   32'(e_ptr));
    chk({pfx, ".bits"}, 32'(bits_left), e_bits);
    chk({pfx, ".unf"},  32'(underrun),  32'(e_unf));
    chk({pfx, ".ovr"},  32'(overrun),   32'(e_ovr));
  endtask

  typedef struct {
    bit         rst, pcen_n, ben_n, ld, sh, wr, clr;
    logic [7:0] din;
    logic       e_bit;
    logic [3:0] e_nib;
    logic       e_full, e_ptr;
    int         e_bits;
    logic       e_unf, e_ovr;
  } vec_t;

  vec_t tbl[5];

  initial begin : main
    logic [15:0] w16;
    int          exp_nib;

    tbl[0] = '{1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 4'h0, 0, 0,  0, 0, 0};  // reset
    tbl[1] = '{0, 0, 1, 0, 0, 1, 0, 8'h34, 0, 4'h0, 0, 1,  0, 0, 0};  // low byte
    tbl[2] = '{0, 0, 1, 0, 0, 1, 0, 8'h12, 0, 4'h0, 1, 0,  0, 0, 0};  // high byte
    tbl[3] = '{0, 1, 1, 1, 1, 1, 0, 8'h55, 0, 4'h0, 1, 0,  0, 0, 0};  // enable high
    tbl[4] = '{0, 0, 1, 1, 0, 0, 0, 8'h00, 0, 4'h1, 0, 0, 16, 0, 0};  // load 0x1234

    rst = 1; pcen_n = 0; ben_n = 1; ld = 0; sh = 0; wr = 0; clr = 0; din = 8'h00;
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].rst, tbl[i].pcen_n, tbl[i].ben_n, tbl[i].ld, tbl[i].sh,
            tbl[i].wr, tbl[i].clr, tbl[i].din);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_bit, tbl[i].e_nib, tbl[i].e_full,
              tbl[i].e_ptr, tbl[i].e_bits, tbl[i].e_unf, tbl[i].e_ovr);
    end

    // 1-bit mode walk through 0x1234
    w16 = 16'h1234;
    for (int k = 1; k <= 16; k++) begin
      drive(0, 0, 1, 0, 1, 0, 0, 8'h00);
      chk($sformatf("shift1.bit%0d", k), 32'(msk_bit), (k < 16) ? 32'(w16[15-k]) : 32'd0);
      chk($sformatf("shift1.bits%0d", k), 32'(bits_left), 32'(16 - k));
    end
    drive(0, 0, 1, 0, 1, 0, 0, 8'h00);
    chk("underrun.flag", 32'(underrun), 1);
    chk("underrun.bit", 32'(msk_bit), 0);
    chk("underrun.bits", 32'(bits_left), 0);

    // 4-bit mode on a fresh 0xA5C3
    drive(0, 0, 0, 0, 0, 1, 0, 8'hC3);
    drive(0, 0, 0, 0, 0, 1, 0, 8'hA5);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h00);
    chk("nib4.load.nib", 32'(msk_nib), 32'hA);
    chk("nib4.load.bits", 32'(bits_left), 16);
    chk("nib4.load.full", 32'(stg_full), 0);
    w16 = 16'hA5C3;
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
      exp_nib = (k < 4) ? ((int'(w16) >> (12 - 4 * k)) & 15) : 0;
      chk($sformatf("nib4.nib%0d", k), 32'(msk_nib), exp_nib);
      chk($sformatf("nib4.bits%0d", k), 32'(bits_left), 32'(16 - 4 * k));
    end

    // Empty stage: held mask is reused
    drive(0, 0, 0, 1, 0, 0, 0, 8'h00);
    chk("reuse.nib", 32'(msk_nib), 32'hA);
    chk("reuse.bit", 32'(msk_bit), 1);
    chk("reuse.bits", 32'(bits_left), 16);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("reuse.nib2", 32'(msk_nib), 32'h5);

    // Load + shift + write together while 0xBEEF is staged
    drive(0, 0, 1, 0, 0, 1, 0, 8'hEF);
    drive(0, 0, 1, 0, 0, 1, 0, 8'hBE);
    chk("beef.full", 32'(stg_full), 1);
    drive(0, 0, 1, 1, 1, 1, 0, 8'h77);
    chk("combo.nib", 32'(msk_nib), 32'hB);
    chk("combo.bits", 32'(bits_left), 16);
    chk("combo.ptr", 32'(stg_ptr), 1);
    chk("combo.full", 32'(stg_full), 0);
    w16 = 16'hBEEF;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
      chk($sformatf("combo.nib%0d", k), 32'(msk_nib), (int'(w16) >> (12 - 4 * k)) & 15);
    end

    // Overrun: third byte while full is dropped
    drive(0, 0, 1, 0, 0, 1, 0, 8'h88);
    chk("ovr.pre.full", 32'(stg_full), 1);
    chk("ovr.pre.flag", 32'(overrun), 0);
    drive(0, 0, 1, 0, 0, 1, 0, 8'h99);
    chk("ovr.flag", 32'(overrun), 1);
    chk("ovr.full", 32'(stg_full), 1);
    chk("ovr.ptr", 32'(stg_ptr), 0);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h00);
    w16 = 16'h8877;
    chk("ovr.nib0", 32'(msk_nib), 32'h8);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
      chk($sformatf("ovr.nib%0d", k), 32'(msk_nib), (int'(w16) >> (12 - 4 * k)) & 15);
    end

    // Clear beats a same-cycle write
    drive(0, 0, 1, 0, 0, 1, 0, 8'h11);
    chk("clr.pre.ptr", 32'(stg_ptr), 1);
    drive(0, 0, 1, 0, 0, 1, 1, 8'h22);
    chk("clr.ptr", 32'(stg_ptr), 0);
    chk("clr.full", 32'(stg_full), 0);
    drive(0, 0, 1, 0, 0, 1, 0, 8'h33);
    drive(0, 0, 1, 0, 0, 1, 0, 8'h44);
    chk("clr.refill", 32'(stg_full), 1);
    drive(0, 0, 1, 1, 0, 0, 0, 8'h00);
    chk("clr.word", 32'(msk_nib), 32'h4);

    // Reset mid-word with the enable inactive
    drive(0, 0, 1, 0, 0, 1, 0, 8'h5A);
    drive(1, 1, 1, 1, 1, 1, 0, 8'hFF);
    chk_all("rstmid", 0, 4'h0, 0, 0, 0, 0, 0);

    // 4-bit shift saturating below one nibble does not flag underrun
    drive(0, 0, 1, 0, 0, 1, 0, 8'h01);
    drive(0, 0, 1, 0, 0, 1, 0, 8'h80);
    drive(0, 0, 1, 1, 0, 0, 0, 8'h00);
    chk("sat.bit", 32'(msk_bit), 1);
    drive(0, 0, 1, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 1, 0, 0, 8'h00);
    chk("sat.bits14", 32'(bits_left), 14);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("sat.bits2", 32'(bits_left), 2);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("sat.bits0", 32'(bits_left), 0);
    chk("sat.nounf", 32'(underrun), 0);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("sat.unf", 32'(underrun), 1);

    // Random traffic against the reference model
    drive(1, 0, 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
            $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
      chk_all($sformatf("rnd%0d", i), 1'((m_sr >> 15) & 1), 4'((m_sr >> 12) & 15),
              m_full, 1'(m_ptr), m_bits, m_unf, m_ovr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
